// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, reset constants and address decode for clint_timer.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package clint_pkg;

   // Byte offsets inside the block. Bits [1:0] are always ignored by decode.
   localparam logic [4:0] CLINT_MSIP        = 5'h00;
   localparam logic [4:0] CLINT_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] CLINT_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] CLINT_MTIME_LO    = 5'h10;
   localparam logic [4:0] CLINT_MTIME_HI    = 5'h14;

   // mtimecmp powers up at the maximum so timer_irq stays low until software arms it.
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_MSIP,
      SEL_MTIMECMP_LO,
      SEL_MTIMECMP_HI,
      SEL_MTIME_LO,
      SEL_MTIME_HI
   } reg_sel_e;

   // Word-aligned decode; unmapped offsets map to SEL_NONE.
   function automatic reg_sel_e clint_decode(input logic [4:0] addr);
      logic [4:0] word_addr;
      word_addr = {addr[4:2], 2'b00};
      case (word_addr)
         CLINT_MSIP:        return SEL_MSIP;
         CLINT_MTIMECMP_LO: return SEL_MTIMECMP_LO;
         CLINT_MTIMECMP_HI: return SEL_MTIMECMP_HI;
         CLINT_MTIME_LO:    return SEL_MTIME_LO;
         CLINT_MTIME_HI:    return SEL_MTIME_HI;
         default:           return SEL_NONE;
      endcase
   endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// clint_tick_gen: prescaler producing one tick every TICK_DIV core clocks.
// Latency: tick is combinational from the counter; restart takes effect at the next edge.
// Backpressure: none; free-running, restart forces the count back to 0.
// Ports: clk, rst (sync, active-high), restart (reload count to 0), tick (mtime increment strobe).
module clint_tick_gen #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // With TICK_DIV=1 LAST is 0, so the counter sits at 0 and tick is constant high.
   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: machine timer (mtime/mtimecmp) and software interrupt (msip) registers.
// Latency: every access answered one cycle after the request; timer_irq lags the compare by one cycle.
// Backpressure: none; always ready, accepts a request every cycle.
// Ports: clk, rst (sync, active-high); req_valid/req_we/req_addr/req_wdata bus request;
//        resp_valid/resp_rdata response; timer_irq (mtime >= mtimecmp, registered); soft_irq (msip[0]).
// Build option: define CLINT_MSIP_EN to implement msip; otherwise offset 0x00 is unmapped and soft_irq=0.
module clint_timer
   import clint_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        timer_irq,
   output logic        soft_irq
);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [31:0] msip_rd;
   logic [31:0] rd_mux;
   logic        tick;
   logic        wr_en;
   logic        wr_mtime_lo;
   logic        wr_mtime_hi;
   reg_sel_e    sel;

   // Byte-lane bits are ignored by the decode.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[1:0];

   assign sel         = clint_decode(req_addr);
   assign wr_en       = req_valid && req_we;
   assign wr_mtime_lo = wr_en && (sel == SEL_MTIME_LO);
   assign wr_mtime_hi = wr_en && (sel == SEL_MTIME_HI);

   clint_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .restart (wr_mtime_lo || wr_mtime_hi),
      .tick    (tick)
   );

   // A half write replaces the increment for that cycle, so a low-half write
   // also drops any carry the tick would have pushed into the high half.
   always_ff @(posedge clk) begin
      if (rst) begin
         mtime <= '0;
      end else if (wr_mtime_lo) begin
         mtime[31:0] <= req_wdata;
      end else if (wr_mtime_hi) begin
         mtime[63:32] <= req_wdata;
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtimecmp <= MTIMECMP_RST;
      end else if (wr_en && (sel == SEL_MTIMECMP_LO)) begin
         mtimecmp[31:0] <= req_wdata;
      end else if (wr_en && (sel == SEL_MTIMECMP_HI)) begin
         mtimecmp[63:32] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_irq <= 1'b0;
      end else begin
         timer_irq <= (mtime >= mtimecmp);
      end
   end

`ifdef CLINT_MSIP_EN
   logic msip;

   always_ff @(posedge clk) begin
      if (rst) begin
         msip <= 1'b0;
      end else if (wr_en && (sel == SEL_MSIP)) begin
         msip <= req_wdata[0];
      end
   end

   assign soft_irq = msip;
   assign msip_rd  = {31'b0, msip};
`else
   assign soft_irq = 1'b0;
   assign msip_rd  = '0;
`endif

   always_comb begin
      rd_mux = '0;
      case (sel)
         SEL_MSIP:        rd_mux = msip_rd;
         SEL_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
         SEL_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
         SEL_MTIME_LO:    rd_mux = mtime[31:0];
         SEL_MTIME_HI:    rd_mux = mtime[63:32];
         default:         rd_mux = '0;
      endcase
   end

   // Read data is captured from the pre-edge register values; writes answer 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= req_valid;
         resp_rdata <= (req_valid && !req_we) ? rd_mux : 32'd0;
      end
   end

endmodule

// File: tb/tb_clint_timer.sv
module tb_clint_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;

   logic        rv1, rv4, ti1, ti4, si1, si4;
   logic [31:0] rd1, rd4;

   int checks = 0;
   int errors = 0;

`ifdef CLINT_MSIP_EN
   localparam logic MSIP_ON = 1'b1;
`else
   localparam logic MSIP_ON = 1'b0;
`endif

   always #5 clk = ~clk;

   clint_timer #(.TICK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
      .resp_rdata(rd1), .timer_irq(ti1), .soft_irq(si1)
   );

   clint_timer #(.TICK_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv4),
      .resp_rdata(rd4), .timer_irq(ti4), .soft_irq(si4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle read; on return the outputs show the response cycle.
   task automatic rd(input logic [4:0] addr, output logic [31:0] d1, output logic [31:0] d4);
      req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = '0;
      step();
      d1 = rd1; d4 = rd4;
      req_valid = 1'b0;
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
      step();
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] a, b;
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h08; req_wdata = '0;
      step(); step();
      checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", rv1); end
      checks++; if (rd1 !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata: got %h expected 0", rd1); end
      checks++; if (ti1 !== 1'b0 || ti4 !== 1'b0) begin errors++; $display("FAIL rst_timer_irq: got %b/%b expected 0/0", ti1, ti4); end
      checks++; if (si1 !== 1'b0) begin errors++; $display("FAIL rst_soft_irq: got %b expected 0", si1); end
      rst = 1'b0;
      rd(5'h10, a, b);
      checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL rd_resp_valid: got %b expected 1", rv1); end
      checks++; if (a !== 32'd0 || b !== 32'd0) begin errors++; $display("FAIL rst_mtime_lo: got %h/%h expected 0/0", a, b); end
      rd(5'h14, a, b);
      checks++; if (a !== 32'd0 || b !== 32'd0) begin errors++; $display("FAIL rst_mtime_hi: got %h/%h expected 0/0", a, b); end
      rd(5'h08, a, b);
      checks++; if (a !== 32'hFFFF_FFFF || b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_lo: got %h/%h expected ffffffff", a, b); end
      rd(5'h0C, a, b);
      checks++; if (a !== 32'hFFFF_FFFF || b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_hi: got %h/%h expected ffffffff", a, b); end
      checks++; if (ti1 !== 1'b0 || ti4 !== 1'b0) begin errors++; $display("FAIL idle_timer_irq: got %b/%b expected 0/0", ti1, ti4); end
   endtask

   // TICK_DIV=1: mtime = k-1 in cycle Ck after the mtime_lo write; cmp=10 from C3.
   task automatic test_compare();
      logic exp;
      wr(5'h14, 32'd0);
      wr(5'h10, 32'd0);          // now C1, mtime=0
      wr(5'h08, 32'd10);         // now C2, mtime=1
      wr(5'h0C, 32'd0);          // now C3, mtime=2
      for (int i = 0; i < 12; i++) begin
         exp = (i >= 9);         // mtime=10 in C11, irq visible in C12
         checks++; if (ti1 !== exp) begin errors++; $display("FAIL cmp_rise[%0d]: got %b expected %b", i, ti1, exp); end
         step();
      end
      wr(5'h08, 32'hFFFF_FFFF);
      checks++; if (ti1 !== 1'b1) begin errors++; $display("FAIL cmp_fall_lag: got %b expected 1", ti1); end
      step();
      checks++; if (ti1 !== 1'b0) begin errors++; $display("FAIL cmp_fall: got %b expected 0", ti1); end
      wr(5'h0C, 32'hFFFF_FFFF);
   endtask

   task automatic test_carry();
      logic [31:0] a, b;
      wr(5'h14, 32'd0);
      wr(5'h10, 32'hFFFF_FFFE);
      step(); step();
      rd(5'h10, a, b);
      checks++; if (a !== 32'd0) begin errors++; $display("FAIL carry_lo: got %h expected 0", a); end
      checks++; if (b !== 32'hFFFF_FFFE) begin errors++; $display("FAIL carry_lo_div4: got %h expected fffffffe", b); end
      rd(5'h14, a, b);
      checks++; if (a !== 32'd1) begin errors++; $display("FAIL carry_hi: got %h expected 1", a); end
      checks++; if (b !== 32'd0) begin errors++; $display("FAIL carry_hi_div4: got %h expected 0", b); end
      // Low-half write at 0x0_FFFFFFFF must not carry into the high half.
      wr(5'h14, 32'd0);
      wr(5'h10, 32'hFFFF_FFFF);
      wr(5'h10, 32'd5);
      rd(5'h14, a, b);
      checks++; if (a !== 32'd0 || b !== 32'd0) begin errors++; $display("FAIL nocarry_hi: got %h/%h expected 0/0", a, b); end
      rd(5'h10, a, b);
      checks++; if (a !== 32'd6 || b !== 32'd5) begin errors++; $display("FAIL nocarry_lo: got %h/%h expected 6/5", a, b); end
      // Full 64-bit wrap.
      wr(5'h14, 32'hFFFF_FFFF);
      wr(5'h10, 32'hFFFF_FFFF);
      step();
      rd(5'h14, a, b);
      checks++; if (a !== 32'd0 || b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_hi: got %h/%h expected 0/ffffffff", a, b); end
      rd(5'h10, a, b);
      checks++; if (a !== 32'd1 || b !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_lo: got %h/%h expected 1/ffffffff", a, b); end
   endtask

   // Back-to-back reads of mtime_lo starting in the write's response cycle.
   task automatic test_back_to_back();
      logic [31:0] exp4;
      wr(5'h10, 32'd100);
      checks++; if (rv4 !== 1'b1 || rd4 !== 32'd0) begin errors++; $display("FAIL wr_resp: got %b/%h expected 1/0", rv4, rd4); end
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h10;
      for (int i = 0; i < 5; i++) begin
         step();
         exp4 = (i < 4) ? 32'd100 : 32'd101;
         checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, rv1); end
         checks++; if (rd4 !== exp4) begin errors++; $display("FAIL presc_hold[%0d]: got %0d expected %0d", i, rd4, exp4); end
         checks++; if (rd1 !== 32'd100 + 32'(i)) begin errors++; $display("FAIL b2b_inc[%0d]: got %0d expected %0d", i, rd1, 100 + i); end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_msip();
      logic [31:0] a, b;
      wr(5'h00, 32'hFFFF_FFFF);
      checks++; if (si1 !== MSIP_ON || si4 !== MSIP_ON) begin errors++; $display("FAIL msip_set: got %b/%b expected %b", si1, si4, MSIP_ON); end
      rd(5'h00, a, b);
      checks++; if (a !== {31'd0, MSIP_ON}) begin errors++; $display("FAIL msip_read: got %h expected %h", a, {31'd0, MSIP_ON}); end
      wr(5'h00, 32'd0);
      checks++; if (si1 !== 1'b0) begin errors++; $display("FAIL msip_clr: got %b expected 0", si1); end
   endtask

   task automatic test_unmapped();
      logic [31:0] a, b;
      wr(5'h08, 32'h1234_5678);
      rd(5'h0B, a, b);
      checks++; if (a !== 32'h1234_5678) begin errors++; $display("FAIL addr_lsb_ignored: got %h expected 12345678", a); end
      rd(5'h04, a, b);
      checks++; if (a !== 32'd0) begin errors++; $display("FAIL unmapped_04: got %h expected 0", a); end
      wr(5'h1C, 32'hDEAD_BEEF);
      checks++; if (rv1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL unmapped_wr_resp: got %b/%h expected 1/0", rv1, rd1); end
      rd(5'h1C, a, b);
      checks++; if (a !== 32'd0) begin errors++; $display("FAIL unmapped_1c: got %h expected 0", a); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] a, b;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h0C; rst = 1'b1;
      step();
      checks++; if (rv1 !== 1'b0 || rv4 !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %b/%b expected 0/0", rv1, rv4); end
      rst = 1'b0;
      rd(5'h10, a, b);
      checks++; if (a !== 32'd0 || b !== 32'd0) begin errors++; $display("FAIL midrst_mtime: got %h/%h expected 0/0", a, b); end
      rd(5'h08, a, b);
      checks++; if (a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midrst_cmp: got %h expected ffffffff", a); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      test_reset();
      test_compare();
      test_carry();
      test_back_to_back();
      test_msip();
      test_unmapped();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
